// File: rtl/dpram_sync_if.sv
// Write/read port bundle for dpram_sync: the pattern generator is the master,
// the line buffer is the slave.
interface dpram_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output data, write_addr, we, read_addr,
        input  q
    );

    modport slave (
        input  data, write_addr, we, read_addr,
        output q
    );
endinterface

// File: rtl/dpram_sync.sv
// One-line buffer of scaled FFT magnitudes: simple dual-port RAM on the pixel clock
// with a registered read port. Define DPRAM_BYPASS_EN for write-first collisions.
module dpram_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 2048
) (
    input  logic         clk,
    input  logic         rstn,
    dpram_sync_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic             wr_in_range;
    logic             rd_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Addresses at or beyond DEPTH never alias onto low words.
    assign wr_in_range = {1'b0, bus.write_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, bus.read_addr} < DEPTH_W;
    assign wr_idx      = bus.write_addr[IDX_W-1:0];
    assign rd_idx      = bus.read_addr[IDX_W-1:0];

    // NOTE: the array has no reset so it maps onto block RAM; its power-up zero
    // comes from the declaration initialiser, which RAM primitives support.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // NOTE: sequential state is always updated with non-blocking assignments so
    // the read below sees the pre-edge contents (read-first behaviour).
    always_ff @(posedge clk) begin
        if (rstn && bus.we && wr_in_range) begin
            mem[wr_idx] <= bus.data;
        end
    end

    logic [DATA_WIDTH-1:0] rd_q;

`ifdef DPRAM_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q    <= '0;
            byp_hit <= 1'b0;
            byp_q   <= '0;
        end else begin
            rd_q    <= rd_in_range ? mem[rd_idx] : '0;
            byp_hit <= bus.we && rd_in_range && (bus.write_addr == bus.read_addr);
            if (bus.we) begin
                byp_q <= bus.data;
            end
        end
    end

    // Write-first: the registered collision flag steers the freshly written word out.
    assign bus.q = byp_hit ? byp_q : rd_q;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    assign bus.q = rd_q;
`endif
endmodule

// File: tb/tb_dpram_sync.sv
// Directed self-checking bench for dpram_sync: reset, read/write latency,
// collisions, out-of-range addresses, mid-operation reset and a full line sweep.
module tb_dpram_sync;
    localparam int DW = 32;
    localparam int AW = 13;

    logic clk;
    logic rstn;
    int   total;
    int   passed;

    dpram_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(2048)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [AW-1:0] addr, input logic [DW-1:0] value);
        bus.write_addr = addr;
        bus.data       = value;
        bus.we         = 1'b1;
        step();
        bus.we         = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] coll_exp;
        total          = 0;
        passed         = 0;
        rstn           = 1'b0;
        bus.we         = 1'b0;
        bus.data       = '0;
        bus.write_addr = '0;
        bus.read_addr  = 13'd5;

        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", bus.q, '0);
        end

        rstn = 1'b1;
        step();
        check("init_zero_5", bus.q, '0);

        write(13'd10, 32'h1234_5678);
        write(13'd255, 32'hDEAD_BEEF);
        bus.read_addr = 13'd10;
        step();
        check("read_10", bus.q, 32'h1234_5678);
        bus.read_addr = 13'd255;
        #1;
        check("read_latency_hold", bus.q, 32'h1234_5678);
        step();
        check("read_255", bus.q, 32'hDEAD_BEEF);

        write(13'd42, 32'hAAAA_0000);
        bus.read_addr = 13'd42;
        write(13'd42, 32'h0000_5555);
`ifdef DPRAM_BYPASS_EN
        coll_exp = 32'h0000_5555;
`else
        coll_exp = 32'hAAAA_0000;
`endif
        check("collision", bus.q, coll_exp);
        step();
        check("after_collision", bus.q, 32'h0000_5555);

        write(13'd20, 32'h0000_0011);
        write(13'd20, 32'h0000_0022);
        bus.read_addr = 13'd20;
        step();
        check("last_write_wins", bus.q, 32'h0000_0022);

        write(13'd2048, 32'hFFFF_FFFF);
        bus.read_addr = 13'd10;
        step();
        check("pre_oor_read", bus.q, 32'h1234_5678);
        bus.read_addr = 13'd2048;
        step();
        check("oor_read_zero", bus.q, '0);
        bus.read_addr = 13'd0;
        step();
        check("no_alias_0", bus.q, '0);
        bus.read_addr = 13'd8191;
        write(13'd8191, 32'h7777_7777);
        check("oor_collision", bus.q, '0);

        write(13'd7, 32'hCAFE_F00D);
        bus.read_addr = 13'd7;
        step();
        check("pre_reset_7", bus.q, 32'hCAFE_F00D);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_q", bus.q, '0);
        bus.write_addr = 13'd7;
        bus.data       = 32'h0000_0001;
        bus.we         = 1'b1;
        step();
        check("reset_q_held", bus.q, '0);
        bus.we = 1'b0;
        rstn   = 1'b1;
        step();
        check("retained_7", bus.q, 32'hCAFE_F00D);

        for (int i = 0; i < 1280; i++) begin
            write(AW'(i), DW'(i));
        end
        for (int i = 0; i < 1280; i++) begin
            bus.read_addr = AW'(i);
            step();
            check("sweep", bus.q, DW'(i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
